// File: rtl/hdmi_i2c_config_sequencer_if.sv
// Command/handshake bundle between the HDMI config sequencer and the I2C engine.
// The sequencer is the master; the I2C engine is the slave.
interface hdmi_i2c_config_sequencer_if;
   logic [23:0] dataOut;
   logic        i2cGo;
   logic        i2cComplete;

   modport master (
      output dataOut,
      output i2cGo,
      input  i2cComplete
   );

   modport slave (
      input  dataOut,
      input  i2cGo,
      output i2cComplete
   );
endinterface

// File: rtl/hdmi_i2c_config_sequencer.sv
// Walks a register table and issues one 24-bit I2C write per entry to bring up
// the HDMI transmitter, with timeout/retry and hot-plug triggered reprogramming.
module hdmi_i2c_config_sequencer #(
   parameter logic [7:0] SLAVE_ADDR     = 8'h72,
   parameter int         NUM_WRITES     = 32,
   parameter int         INDEX_WIDTH    = 6,
   parameter int         STARTUP_CYCLES = 10_000_000,
   parameter int         GAP_CYCLES     = 500,
   parameter int         TIMEOUT_CYCLES = 50_000,
   parameter int         MAX_RETRIES    = 3
) (
   input  logic                       refClock,
   input  logic                       reset_n,
   input  logic                       hpd,
   output logic [INDEX_WIDTH-1:0]     tableIndex,
   input  logic [15:0]                tableData,
   hdmi_i2c_config_sequencer_if.master i2c,
   output logic                       configDone,
   output logic                       configError
);

   localparam int RW = $clog2(MAX_RETRIES + 1);

   localparam logic [23:0] STARTUP_LAST = 24'(STARTUP_CYCLES - 1);
   localparam logic [23:0] GAP_LAST     = 24'(GAP_CYCLES - 1);
   localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

   localparam logic [INDEX_WIDTH-1:0] INDEX_LAST = INDEX_WIDTH'(NUM_WRITES - 1);
   localparam logic [RW-1:0]          RETRY_LAST = RW'(MAX_RETRIES - 1);

   typedef enum logic [3:0] {
      S_STARTUP,
      S_LOAD,
      S_GO,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_RETRY,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_t;

   state_t         state;
   logic [23:0]    cnt;
   logic [RW-1:0]  retries;
   logic           success;
   logic           hpd_meta;
   logic           hpd_sync;
   logic           hpd_prev;
   logic           hpdPending;

   always_ff @(posedge refClock) begin
      if (!reset_n) begin
         state       <= S_STARTUP;
         cnt         <= '0;
         retries     <= '0;
         success     <= 1'b0;
         hpd_meta    <= 1'b0;
         hpd_sync    <= 1'b0;
         hpd_prev    <= 1'b0;
         hpdPending  <= 1'b0;
         tableIndex  <= '0;
         i2c.dataOut <= '0;
         i2c.i2cGo   <= 1'b0;
         configDone  <= 1'b0;
         configError <= 1'b0;
      end else begin
         hpd_meta <= hpd;
         hpd_sync <= hpd_meta;
         hpd_prev <= hpd_sync;

         unique case (state)
            S_STARTUP: begin
               tableIndex <= '0;
               retries    <= '0;
               if (cnt == STARTUP_LAST) begin
                  cnt   <= '0;
                  state <= S_LOAD;
               end else begin
                  cnt <= cnt + 24'd1;
               end
            end

            S_LOAD: begin
               i2c.dataOut <= {SLAVE_ADDR, tableData};
               state       <= S_GO;
            end

            S_GO: begin
               i2c.i2cGo <= 1'b1;
               cnt       <= '0;
               state     <= S_WAIT_BUSY;
            end

            // Go stays high until the engine, on its slower clock, reports busy.
            S_WAIT_BUSY: begin
               if (!i2c.i2cComplete) begin
                  i2c.i2cGo <= 1'b0;
                  cnt       <= '0;
                  state     <= S_WAIT_DONE;
               end else if (cnt == TIMEOUT_LAST) begin
                  state <= S_RETRY;
               end else begin
                  cnt <= cnt + 24'd1;
               end
            end

            S_WAIT_DONE: begin
               if (i2c.i2cComplete) begin
                  success <= 1'b1;
                  cnt     <= '0;
                  state   <= S_GAP;
               end else if (cnt == TIMEOUT_LAST) begin
                  state <= S_RETRY;
               end else begin
                  cnt <= cnt + 24'd1;
               end
            end

            S_RETRY: begin
               i2c.i2cGo <= 1'b0;
               retries   <= retries + RW'(1);
               cnt       <= '0;
               if (retries == RETRY_LAST) begin
                  configError <= 1'b1;
                  state       <= S_ERROR;
               end else begin
                  success <= 1'b0;
                  state   <= S_GAP;
               end
            end

            // A pending hot-plug beats the normal advance and restarts at 0.
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (hpdPending) begin
                     hpdPending <= 1'b0;
                     tableIndex <= '0;
                     retries    <= '0;
                     success    <= 1'b0;
                     state      <= S_LOAD;
                  end else if (!success) begin
                     state <= S_LOAD;
                  end else if (tableIndex == INDEX_LAST) begin
                     configDone <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     tableIndex <= tableIndex + INDEX_WIDTH'(1);
                     retries    <= '0;
                     state      <= S_LOAD;
                  end
               end else begin
                  cnt <= cnt + 24'd1;
               end
            end

            S_DONE: begin
               if (hpdPending) begin
                  hpdPending <= 1'b0;
                  configDone <= 1'b0;
                  tableIndex <= '0;
                  retries    <= '0;
                  success    <= 1'b0;
                  cnt        <= '0;
                  state      <= S_GAP;
               end
            end

            S_ERROR: begin
               i2c.i2cGo <= 1'b0;
               if (hpdPending) begin
                  hpdPending  <= 1'b0;
                  configError <= 1'b0;
                  tableIndex  <= '0;
                  retries     <= '0;
                  success     <= 1'b0;
                  cnt         <= '0;
                  state       <= S_GAP;
               end
            end

            default: state <= S_STARTUP;
         endcase

         // A fresh edge wins over a same-cycle clear so it is never lost.
         if (hpd_sync && !hpd_prev) hpdPending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hdmi_i2c_config_sequencer.sv
// Directed bench for hdmi_i2c_config_sequencer with a small I2C engine model
// and a combinational three-entry register ROM.
module tb_hdmi_i2c_config_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hpd = 1'b0;
   logic [5:0]  tableIndex;
   logic [15:0] tableData;
   logic        configDone;
   logic        configError;

   hdmi_i2c_config_sequencer_if bus();

   hdmi_i2c_config_sequencer #(
      .SLAVE_ADDR     (8'h72),
      .NUM_WRITES     (3),
      .INDEX_WIDTH    (6),
      .STARTUP_CYCLES (10),
      .GAP_CYCLES     (4),
      .TIMEOUT_CYCLES (50),
      .MAX_RETRIES    (2)
   ) dut (
      .refClock    (clk),
      .reset_n     (reset_n),
      .hpd         (hpd),
      .tableIndex  (tableIndex),
      .tableData   (tableData),
      .i2c         (bus),
      .configDone  (configDone),
      .configError (configError)
   );

   always #5 clk = ~clk;

   always_comb begin
      tableData = 16'h0000;
      case (tableIndex)
         6'd0:    tableData = 16'h4110;
         6'd1:    tableData = 16'h9803;
         6'd2:    tableData = 16'hD6C0;
         default: tableData = 16'h0000;
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= reset_n ? cyc + 1 : 0;

   // Engine model: 0 normal, 1 never responds, 2 ignores first try at entry 1
   int mode = 0;
   bit skipped = 0;
   bit m_busy = 0;
   bit m_go = 0;
   int m_cnt = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         bus.i2cComplete = 1'b1;
         m_busy = 0;
         m_cnt = 0;
         m_go = 0;
      end else begin
         if (m_busy) begin
            m_cnt++;
            if (m_cnt == 5) bus.i2cComplete = 1'b0;
            else if (m_cnt == 25) begin
               bus.i2cComplete = 1'b1;
               m_busy = 0;
            end
         end
         if (bus.i2cGo && !m_go) begin
            if (mode == 2 && bus.dataOut == 24'h729803 && !skipped) skipped = 1;
            else if (mode != 1) begin
               m_busy = 1;
               m_cnt = 0;
            end
         end
         m_go = bus.i2cGo;
      end
   end

   logic [23:0] tx_data[$];
   int          tx_cyc[$];
   logic [23:0] go_data = '0;
   int stab_bad = 0;
   int fall_cyc = -1;
   int done_cyc = -1;
   int done_fall_cyc = -1;
   int err_cyc = -1;
   bit mon_go = 0;
   bit mon_done = 0;
   bit mon_err = 0;

   always @(negedge clk) begin
      if (bus.i2cGo && !mon_go) begin
         tx_data.push_back(bus.dataOut);
         tx_cyc.push_back(cyc);
         go_data = bus.dataOut;
      end else if (bus.i2cGo && bus.dataOut !== go_data) begin
         stab_bad++;
      end
      if (!bus.i2cGo && mon_go && fall_cyc < 0) fall_cyc = cyc;
      if (configDone && !mon_done) done_cyc = cyc;
      if (!configDone && mon_done) done_fall_cyc = cyc;
      if (configError && !mon_err) err_cyc = cyc;
      mon_go = bus.i2cGo;
      mon_done = configDone;
      mon_err = configError;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      tx_data.delete();
      tx_cyc.delete();
      fall_cyc = -1;
      done_cyc = -1;
      done_fall_cyc = -1;
      err_cyc = -1;
   endtask

   task automatic apply_reset(input int m);
      reset_n = 1'b0;
      hpd = 1'b0;
      mode = m;
      skipped = 0;
      clear_log();
      repeat (2) step();
      reset_n = 1'b1;
   endtask

   task automatic check_tx(input string tag, input int i,
                           input logic [23:0] d, input int c);
      if (i < tx_data.size()) begin
         check({tag, "_data"}, 32'(tx_data[i]), 32'(d));
         check({tag, "_cyc"}, tx_cyc[i], c);
      end else begin
         check({tag, "_missing"}, tx_data.size(), i + 1);
      end
   endtask

   task automatic wait_flag(input string tag, input bit err, input int budget);
      int n = 0;
      while ((err ? configError : configDone) !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(tag, 32'(err ? configError : configDone), 1);
   endtask

   task automatic pulse_hpd(output int h);
      step();
      hpd = 1'b1;
      h = cyc;
      repeat (4) step();
      hpd = 1'b0;
   endtask

   int h;

   initial begin
      // Normal bring-up
      apply_reset(0);
      check("rst_data", 32'(bus.dataOut), 0);
      check("rst_go", 32'(bus.i2cGo), 0);
      check("rst_idx", 32'(tableIndex), 0);
      check("rst_done", 32'(configDone), 0);
      check("rst_err", 32'(configError), 0);
      wait_flag("t1_done", 0, 400);
      tick();
      check("t1_ntx", tx_data.size(), 3);
      check_tx("t1_tx0", 0, 24'h724110, 12);
      check_tx("t1_tx1", 1, 24'h729803, 44);
      check_tx("t1_tx2", 2, 24'h72D6C0, 76);
      check("t1_go_fall", fall_cyc, 18);
      check("t1_done_cyc", done_cyc, 106);
      check("t1_err", 32'(configError), 0);

      // Hot-plug while done
      clear_log();
      pulse_hpd(h);
      wait_flag("t1h_done", 0, 400);
      tick();
      check("t1h_done_fall", done_fall_cyc, h + 4);
      check("t1h_ntx", tx_data.size(), 3);
      check_tx("t1h_tx0", 0, 24'h724110, h + 10);
      check_tx("t1h_tx1", 1, 24'h729803, h + 42);
      check_tx("t1h_tx2", 2, 24'h72D6C0, h + 74);
      check("t1h_done_cyc", done_cyc, h + 104);

      // Engine never responds
      apply_reset(1);
      wait_flag("t2_err", 1, 400);
      repeat (5) tick();
      check("t2_err_cyc", err_cyc, 120);
      check("t2_ntx", tx_data.size(), 2);
      check_tx("t2_tx0", 0, 24'h724110, 12);
      check_tx("t2_tx1", 1, 24'h724110, 69);
      check("t2_go", 32'(bus.i2cGo), 0);
      check("t2_done", 32'(configDone), 0);
      check("t2_idx", 32'(tableIndex), 0);

      // Hot-plug recovers from error
      mode = 0;
      clear_log();
      pulse_hpd(h);
      wait_flag("t2h_done", 0, 400);
      tick();
      check("t2h_err", 32'(configError), 0);
      check_tx("t2h_tx0", 0, 24'h724110, h + 10);
      check("t2h_ntx", tx_data.size(), 3);

      // One timeout on entry 1
      apply_reset(2);
      wait_flag("t3_done", 0, 400);
      tick();
      check("t3_ntx", tx_data.size(), 4);
      check_tx("t3_tx0", 0, 24'h724110, 12);
      check_tx("t3_tx1", 1, 24'h729803, 44);
      check_tx("t3_tx2", 2, 24'h729803, 101);
      check_tx("t3_tx3", 3, 24'h72D6C0, 133);
      check("t3_done_cyc", done_cyc, 163);
      check("t3_err", 32'(configError), 0);

      // Hot-plug during entry 1 WAIT_DONE
      apply_reset(0);
      while (cyc < 52) step();
      hpd = 1'b1;
      repeat (4) step();
      hpd = 1'b0;
      wait_flag("t4_done", 0, 400);
      repeat (100) tick();
      check("t4_ntx", tx_data.size(), 5);
      check_tx("t4_tx1", 1, 24'h729803, 44);
      check_tx("t4_tx2", 2, 24'h724110, 76);
      check_tx("t4_tx3", 3, 24'h729803, 108);
      check_tx("t4_tx4", 4, 24'h72D6C0, 140);
      check("t4_done_cyc", done_cyc, 170);
      check("t4_done_hold", 32'(configDone), 1);

      // Reset pulse during WAIT_DONE
      apply_reset(0);
      while (cyc < 20) step();
      reset_n = 1'b0;
      clear_log();
      step();
      check("t5_go", 32'(bus.i2cGo), 0);
      check("t5_idx", 32'(tableIndex), 0);
      check("t5_data", 32'(bus.dataOut), 0);
      reset_n = 1'b1;
      wait_flag("t5_done", 0, 400);
      tick();
      check_tx("t5_tx0", 0, 24'h724110, 12);
      check("t5_done_cyc", done_cyc, 106);

      check("data_stable", stab_bad, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
